// File: rtl/mpt_pkg.sv
// mpt_pkg: shared MPT types, the PLB flush modes, cache line layout and access one-hot encodings
package mpt_pkg;

   localparam int MPT_XLEN     = 64;
   localparam int MPT_SDID_LEN = 6;

   typedef enum logic [1:0] {
      FLUSH_ALL  = 2'd0,
      FLUSH_SDID = 2'd1,
      FLUSH_PAGE = 2'd2,
      FLUSH_RSVD = 2'd3
   } plb_flush_e;

   localparam logic [2:0] ACCESS_READ  = 3'b001;
   localparam logic [2:0] ACCESS_WRITE = 3'b010;
   localparam logic [2:0] ACCESS_EXEC  = 3'b100;

   typedef struct packed {
      logic [MPT_SDID_LEN-1:0] sdid;
      logic [MPT_XLEN-1:0]     spa;
      logic [2:0]              perms;
   } plb_entry_t;

   typedef struct packed {
      logic       valid;
      plb_entry_t entry;
   } plb_line_t;

endpackage

// File: rtl/mpt_plb_repl.sv
// mpt_plb_repl: PLB victim selection, lowest invalid entry first, otherwise a round-robin pointer
//   clk_i/rst_i  clock, synchronous active-high reset
//   valid_i      per-entry valid bits
//   advance_i    an allocation happens this cycle
//   victim_o     entry to allocate into
//   evict_o      every entry is valid, so the victim holds a live line
module mpt_plb_repl #(
   parameter int NUM_ENTRIES = 8,
   localparam int IW = $clog2(NUM_ENTRIES)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_ENTRIES-1:0] valid_i,
   input  logic                   advance_i,
   output logic [IW-1:0]          victim_o,
   output logic                   evict_o
);

   logic [IW-1:0] rr_q, rr_d;

   // the pointer only moves when a live line is displaced; power-of-two size wraps for free
   always_comb begin
      evict_o  = &valid_i;
      victim_o = rr_q;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (!valid_i[i]) victim_o = IW'(i);
      rr_d = (advance_i && evict_o) ? rr_q + 1'b1 : rr_q;
   end

   always_ff @(posedge clk_i)
      if (rst_i) rr_q <= '0;
      else rr_q <= rr_d;

endmodule

// File: rtl/mpt_plb_cache.sv
// mpt_plb_cache: fully-associative protection lookaside buffer caching MPT leaf permissions per page and SDID
//   clk_i/rst_i       clock, synchronous active-high reset
//   lookup_*          permission lookup, answered one cycle later on resp_*
//   refill_*          walker writes an entry (updated in place or allocated)
//   flush_*           invalidate all / by SDID / by page
//   hit/miss_count_o  saturating statistics of registered responses
module mpt_plb_cache
   import mpt_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int XLEN        = MPT_XLEN,
   parameter int SDID_LEN    = MPT_SDID_LEN,
   parameter int PAGE_OFFSET = 12,
   parameter int CNT_W       = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                lookup_valid_i,
   input  logic [SDID_LEN-1:0] lookup_sdid_i,
   input  logic [XLEN-1:0]     lookup_spa_i,
   input  logic [2:0]          lookup_access_i,
   output logic                resp_valid_o,
   output logic                resp_hit_o,
   output logic                resp_allow_o,
   output logic [2:0]          resp_perms_o,
   input  logic                refill_valid_i,
   input  logic [SDID_LEN-1:0] refill_sdid_i,
   input  logic [XLEN-1:0]     refill_spa_i,
   input  logic [2:0]          refill_perms_i,
   input  logic                flush_i,
   input  logic [1:0]          flush_mode_i,
   input  logic [SDID_LEN-1:0] flush_sdid_i,
   input  logic [XLEN-1:0]     flush_spa_i,
   output logic [CNT_W-1:0]    hit_count_o,
   output logic [CNT_W-1:0]    miss_count_o
);

   localparam int IW = $clog2(NUM_ENTRIES);

   function automatic logic [XLEN-1:0] page_of(input logic [XLEN-1:0] a);
      return {a[XLEN-1:PAGE_OFFSET], {PAGE_OFFSET{1'b0}}};
   endfunction

   plb_line_t [NUM_ENTRIES-1:0] lines_q, lines_d;
   logic [NUM_ENTRIES-1:0] vld;
   logic [IW-1:0] victim, rf_idx;
   logic evict, alloc, lk_hit, rf_hit, onehot;
   logic [2:0] lk_perms;
   plb_flush_e fmode;
   logic resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d, resp_allow_q, resp_allow_d;
   logic [2:0] resp_perms_q, resp_perms_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   mpt_plb_repl #(.NUM_ENTRIES(NUM_ENTRIES)) u_repl (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (vld),
      .advance_i (alloc),
      .victim_o  (victim),
      .evict_o   (evict)
   );

   // tag match for the lookup and the refill ports against the current state
   always_comb begin
      vld      = '0;
      lk_hit   = 1'b0;
      lk_perms = '0;
      rf_hit   = 1'b0;
      rf_idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         vld[i] = lines_q[i].valid;
         if (vld[i] && lines_q[i].entry.sdid == lookup_sdid_i && lines_q[i].entry.spa == page_of(lookup_spa_i)) begin
            lk_hit   = 1'b1;
            lk_perms = lines_q[i].entry.perms;
         end
         if (vld[i] && lines_q[i].entry.sdid == refill_sdid_i && lines_q[i].entry.spa == page_of(refill_spa_i)) begin
            rf_hit = 1'b1;
            rf_idx = IW'(i);
         end
      end
   end

   // flush wins over refill; a refill to a cached page rewrites it instead of allocating
   always_comb begin
      lines_d = lines_q;
      alloc   = 1'b0;
      fmode   = plb_flush_e'(flush_mode_i);
      for (int i = 0; i < NUM_ENTRIES; i++)
         if (flush_i && (fmode == FLUSH_ALL ||
             (fmode == FLUSH_SDID && lines_q[i].entry.sdid == flush_sdid_i) ||
             (fmode == FLUSH_PAGE && lines_q[i].entry.sdid == flush_sdid_i && lines_q[i].entry.spa == page_of(flush_spa_i))))
            lines_d[i].valid = 1'b0;
      if (!flush_i && refill_valid_i) begin
         lines_d[rf_hit ? rf_idx : victim] = '{valid: 1'b1, entry: '{sdid: refill_sdid_i, spa: page_of(refill_spa_i), perms: refill_perms_i}};
         alloc = !rf_hit;
      end
   end

   // a lookup coinciding with a flush is answered as a miss
   always_comb begin
      onehot       = lookup_access_i inside {ACCESS_READ, ACCESS_WRITE, ACCESS_EXEC};
      resp_valid_d = lookup_valid_i;
      resp_hit_d   = lookup_valid_i && !flush_i && lk_hit;
      resp_perms_d = resp_hit_d ? lk_perms : 3'b000;
      resp_allow_d = resp_hit_d && onehot && ((lk_perms & lookup_access_i) == lookup_access_i);
      hit_cnt_d    = hit_cnt_q + CNT_W'(resp_hit_d && !(&hit_cnt_q));
      miss_cnt_d   = miss_cnt_q + CNT_W'(resp_valid_d && !resp_hit_d && !(&miss_cnt_q));
   end

   always_ff @(posedge clk_i)
      if (rst_i) begin
         lines_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_allow_q <= 1'b0;
         resp_perms_q <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         lines_q      <= lines_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_allow_q <= resp_allow_d;
         resp_perms_q <= resp_perms_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end

   assign resp_valid_o = resp_valid_q;
   assign resp_hit_o   = resp_hit_q;
   assign resp_allow_o = resp_allow_q;
   assign resp_perms_o = resp_perms_q;
   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;

endmodule
